sys_bus_resp_ram: RTL and testbench



---
 rtl/sys_bus_resp_ram.sv | 181 ++++++++++++++++++
 tb/tb_sys_bus_resp_ram.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_resp_ram.sv
// sys_bus_resp_ram: system bus responder. It is a small word-addressed RAM with
// a programmable wait-state count and an error response for bad requests.
//
// Parameters: DW data width, AW byte-address width, RN words (power of two),
//             WAIT extra wait cycles before the response (0..15).
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   wen, ren         single-cycle write / read request pulses
//   addr, wdata      byte address and write data, sampled with the request
//   rdata            read data, updated together with a read ack
//   ack, err         single-cycle success / error completion pulses
// Optional (macro SYS_BUS_RESP_STATS_EN):
//   stat_clr         synchronous clear of the statistics counters
//   rd_cnt, wr_cnt, err_cnt  saturating 16-bit response counters
module sys_bus_resp_ram #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned RN   = 16,
  parameter int unsigned WAIT = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wen,
  input  logic          ren,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          err
`ifdef SYS_BUS_RESP_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   err_cnt
`endif
);

  localparam int unsigned IW = $clog2(RN);
  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] LIMIT = AW'(RN * 4);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic            bad_q, bad_d;
  logic [DW-1:0]   rbuf_q, rbuf_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [RN];

  logic            req_c;
  logic            bad_c;
  logic            we_c;
  logic [IW-1:0]   idx_c;

  // Request decode; full-width range check so high address bits cannot alias.
  assign req_c = wen | ren;
  assign idx_c = addr[2 +: IW];
  assign bad_c = (addr >= LIMIT) || (wen && ren);
  assign we_c  = (state_q == ST_IDLE) && wen && !bad_c;

  // Next-state and response logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    bad_d   = bad_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          rd_d  = ren;
          bad_d = bad_c;
          if (ren) rbuf_d = mem_q[idx_c];
          if (WAIT == 0) begin
            state_d = ST_RESP;
            ack_d   = !bad_c;
            err_d   = bad_c;
            if (ren && !bad_c) rdata_d = mem_q[idx_c];
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(WAIT);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_RESP;
          ack_d   = !bad_q;
          err_d   = bad_q;
          if (rd_q && !bad_q) rdata_d = rbuf_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      bad_q   <= 1'b0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      bad_q   <= bad_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage; cleared by reset so a mid-transaction reset leaves no stale data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < RN; i++) mem_q[i] <= '0;
    end else if (we_c) begin
      mem_q[idx_c] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;

`ifdef SYS_BUS_RESP_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counters bump while the response is on the bus; clear wins over increment.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (stat_clr) begin
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      err_cnt_d = '0;
    end else begin
      if (ack_q && rd_q && (rd_cnt_q != 16'hFFFF))   rd_cnt_d  = rd_cnt_q + 16'd1;
      if (ack_q && !rd_q && (wr_cnt_q != 16'hFFFF))  wr_cnt_d  = wr_cnt_q + 16'd1;
      if (err_q && (err_cnt_q != 16'hFFFF))          err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sys_bus_resp_ram.sv
// Directed bench for sys_bus_resp_ram: one instance with WAIT=0 and one with
// WAIT=3, sharing clock and reset, exercised one after the other.
module tb_sys_bus_resp_ram;

  logic        clk;
  logic        rstn;
  logic        wen0, ren0, wen3, ren3;
  logic [31:0] addr0, wdata0, addr3, wdata3;
  logic [31:0] rdata0, rdata3;
  logic        ack0, err0, ack3, err3;
`ifdef SYS_BUS_RESP_STATS_EN
  logic        stat_clr;
  logic [15:0] rd_cnt0, wr_cnt0, err_cnt0;
  logic [15:0] rd_cnt3, wr_cnt3, err_cnt3;
`endif

  int n_asserts;
  int n_fail;

  sys_bus_resp_ram #(.DW(32), .AW(32), .RN(16), .WAIT(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .wen(wen0), .ren(ren0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0)
`ifdef SYS_BUS_RESP_STATS_EN
    , .stat_clr(stat_clr), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0), .err_cnt(err_cnt0)
`endif
  );

  sys_bus_resp_ram #(.DW(32), .AW(32), .RN(16), .WAIT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .wen(wen3), .ren(ren3), .addr(addr3),
    .wdata(wdata3), .rdata(rdata3), .ack(ack3), .err(err3)
`ifdef SYS_BUS_RESP_STATS_EN
    , .stat_clr(stat_clr), .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3), .err_cnt(err_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      wen3 = w; ren3 = r; addr3 = a; wdata3 = wd;
    end else begin
      wen0 = w; ren0 = r; addr0 = a; wdata0 = wd;
    end
  endtask

  function automatic logic [31:0] resp(input bit d);
    return d ? {30'd0, ack3, err3} : {30'd0, ack0, err0};
  endfunction

  function automatic logic [31:0] rd(input bit d);
    return d ? rdata3 : rdata0;
  endfunction

  // One request pulse, then quiet wait cycles, a single response, and idle.
  task automatic txn(input string tag, input bit d, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic exp_ack, input logic [31:0] exp_rd);
    int lat;
    lat = d ? 3 : 0;
    drive(d, w, r, a, wd);
    step();
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < lat; k++) begin
      chk({tag, "_quiet"}, resp(d), 32'd0);
      step();
    end
    chk({tag, "_resp"}, resp(d), exp_ack ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, rd(d), exp_rd);
    step();
    chk({tag, "_pulse"}, resp(d), 32'd0);
  endtask

  initial begin
    int n_ack, n_err;
    logic [31:0] got;
    n_asserts = 0;
    n_fail    = 0;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef SYS_BUS_RESP_STATS_EN
    stat_clr = 1'b0;
`endif
    step();
    step();
    chk("rst_resp0", resp(1'b0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_resp3", resp(1'b1), 32'd0);
    chk("rst_rdata3", rdata3, 32'd0);
    rstn = 1'b1;
    step();

    // WAIT=0 basic write/read, range errors, simultaneous request.
    txn("w0_wr08", 1'b0, 1'b1, 1'b0, 32'h08, 32'hDEADBEEF, 1'b1, 32'h0);
    txn("w0_rd08", 1'b0, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 32'hDEADBEEF);
    txn("w0_wr40", 1'b0, 1'b1, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'hDEADBEEF);
    txn("w0_rd40", 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF);
    txn("w0_rd3c", 1'b0, 1'b0, 1'b1, 32'h3C, 32'h0, 1'b1, 32'h0);
    txn("w0_both", 1'b0, 1'b1, 1'b1, 32'h00, 32'hA5A5A5A5, 1'b0, 32'h0);
    txn("w0_rd00", 1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 1'b1, 32'h0);
    txn("w0_rd0a", 1'b0, 1'b0, 1'b1, 32'h0A, 32'h0, 1'b1, 32'hDEADBEEF);
    txn("w0_wr3c", 1'b0, 1'b1, 1'b0, 32'h3C, 32'h11, 1'b1, 32'hDEADBEEF);
    txn("w0_rd3c2", 1'b0, 1'b0, 1'b1, 32'h3C, 32'h0, 1'b1, 32'h11);
    txn("w0_rd100", 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 32'h11);
    txn("w0_rdhi", 1'b0, 1'b0, 1'b1, 32'h80000008, 32'h0, 1'b0, 32'h11);

    // WAIT=3 latency and write/read.
    txn("w3_rd04", 1'b1, 1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h0);
    txn("w3_wr04", 1'b1, 1'b1, 1'b0, 32'h04, 32'hCAFE0001, 1'b1, 32'h0);

    // Requests while busy are ignored: one ack, no write to 0x10.
    drive(1'b1, 1'b0, 1'b1, 32'h04, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h08, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h00000BAD);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    n_ack = 0;
    n_err = 0;
    got   = 32'h0;
    for (int k = 0; k < 6; k++) begin
      if (ack3) begin
        n_ack++;
        got = rdata3;
      end
      if (err3) n_err++;
      step();
    end
    chk("w3_busy_acks", 32'(n_ack), 32'd1);
    chk("w3_busy_errs", 32'(n_err), 32'd0);
    chk("w3_busy_rdata", got, 32'hCAFE0001);
    txn("w3_rd10", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0);
    txn("w3_rd08", 1'b1, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 32'h0);

    // Reset during WAIT drops the pending response and clears memory.
    drive(1'b1, 1'b1, 1'b0, 32'h0C, 32'h77);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_resp3", resp(1'b1), 32'd0);
    chk("arst_rdata0", rdata0, 32'd0);
    step();
    step();
    rstn = 1'b1;
    n_ack = 0;
    n_err = 0;
    for (int k = 0; k < 8; k++) begin
      if (ack3) n_ack++;
      if (err3) n_err++;
      step();
    end
    chk("arst_no_ack", 32'(n_ack), 32'd0);
    chk("arst_no_err", 32'(n_err), 32'd0);
    txn("w3_rd0c", 1'b1, 1'b0, 1'b1, 32'h0C, 32'h0, 1'b1, 32'h0);

    // Post-reset traffic on WAIT=0: 3 reads, 2 writes, 1 error.
    txn("w0_rd08r", 1'b0, 1'b0, 1'b1, 32'h08, 32'h0, 1'b1, 32'h0);
    txn("w0_wr00", 1'b0, 1'b1, 1'b0, 32'h00, 32'h5, 1'b1, 32'h0);
    txn("w0_wr04", 1'b0, 1'b1, 1'b0, 32'h04, 32'h6, 1'b1, 32'h0);
    txn("w0_rd00r", 1'b0, 1'b0, 1'b1, 32'h00, 32'h0, 1'b1, 32'h5);
    txn("w0_rd04r", 1'b0, 1'b0, 1'b1, 32'h04, 32'h0, 1'b1, 32'h6);
    txn("w0_rd44", 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 1'b0, 32'h6);
`ifdef SYS_BUS_RESP_STATS_EN
    chk("st_rd", 32'(rd_cnt0), 32'd3);
    chk("st_wr", 32'(wr_cnt0), 32'd2);
    chk("st_err", 32'(err_cnt0), 32'd1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("st_clr_rd", 32'(rd_cnt0), 32'd0);
    chk("st_clr_wr", 32'(wr_cnt0), 32'd0);
    chk("st_clr_err", 32'(err_cnt0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
